// File: rtl/ksa32_pkg.sv
// ---------------------------------------------------------------------------
// ksa32_pkg
// Shared definitions for the packet accumulator and its Kogge-Stone adder.
//   state_t    : accumulator FSM encoding (IDLE / ACCUM / HOLD)
//   DATA_W     : datapath width of operands and sum
//   KSA_LEVELS : number of prefix levels needed to span DATA_W bits
// ---------------------------------------------------------------------------
package ksa32_pkg;

    localparam int DATA_W     = 32;
    localparam int KSA_LEVELS = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : ksa32_pkg

// File: rtl/ksa32_acc_adder.sv
// ---------------------------------------------------------------------------
// KSA32_top
// Purely combinational 32-bit Kogge-Stone adder with carry-in of zero.
// Ports:
//   a, b : operands
//   sum  : a + b mod 2^32
//   cout : unsigned carry out of the MSB
//   ovf  : two's-complement overflow (equal operand signs, different sum sign)
// ---------------------------------------------------------------------------
module KSA32_top
    import ksa32_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    logic [DATA_W-1:0] half_sum;

    assign half_sum = a ^ b;

    // Prefix tree: at each level every bit merges with the bit 2^lvl below.
    // Walking bit positions from the top down lets gen/prop be updated in
    // place, since the lower operand of each merge is still the value from
    // the previous level when it is read. After the last level gen[i] is the
    // carry out of bit i.
    always_comb begin : prefix_tree
        logic [DATA_W-1:0] gen;
        logic [DATA_W-1:0] prop;
        gen  = a & b;
        prop = half_sum;
        for (int lvl = 0; lvl < KSA_LEVELS; lvl++) begin
            for (int i = DATA_W - 1; i >= (1 << lvl); i--) begin
                gen[i]  = gen[i] | (prop[i] & gen[i - (1 << lvl)]);
                prop[i] = prop[i] & prop[i - (1 << lvl)];
            end
        end
        sum  = half_sum ^ {gen[DATA_W-2:0], 1'b0};
        cout = gen[DATA_W-1];
        ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    end

endmodule : KSA32_top

// File: rtl/ksa32_acc.sv
// ---------------------------------------------------------------------------
// ksa32_acc
// Packet accumulator: sums a stream of 32-bit operands per packet (IN_LAST
// marks the final beat) and presents the registered result with sticky
// carry/overflow flags and a saturating beat count.
// Ports:
//   CLK, RST_N          : clock, asynchronous active-low reset
//   IN_VALID/IN_READY   : operand handshake
//   IN_DATA, IN_LAST    : operand and end-of-packet marker
//   OUT_VALID/OUT_READY : result handshake (valid only in HOLD)
//   OUT_SUM             : packet sum mod 2^32
//   OUT_COUT, OUT_OVF   : sticky unsigned carry / signed overflow
//   OUT_COUNT           : beats in the packet, saturating at 2^CNT_W-1
// ---------------------------------------------------------------------------
module ksa32_acc
    import ksa32_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_LAST,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_SUM,
    output logic              OUT_COUT,
    output logic              OUT_OVF,
    output logic [CNT_W-1:0]  OUT_COUNT
);

    localparam logic [CNT_W-1:0] COUNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] COUNT_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic              accept;

    logic [DATA_W-1:0] acc_q;
    logic              cout_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  count_q;

    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              add_ovf;

    logic              cout_d;
    logic              ovf_d;
    logic [CNT_W-1:0]  count_d;

    logic [DATA_W-1:0] res_sum_q;
    logic              res_cout_q;
    logic              res_ovf_q;
    logic [CNT_W-1:0]  res_count_q;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. HOLD never raises IN_READY, so an
    // operand offered during the HOLD-exit cycle waits for IDLE.
    always_comb begin
        state_d   = state_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state_q)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    state_d = IN_LAST ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                IN_READY = 1'b1;
                if (IN_VALID && IN_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = IN_VALID && IN_READY;

    // The first beat of a packet adds to zero so the accumulator simply loads.
    assign add_a = (state_q == ACCUM) ? acc_q : '0;

    KSA32_top u_adder (
        .a    (add_a),
        .b    (IN_DATA),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Flag and count updates for an accepted beat; the first beat restarts them.
    always_comb begin
        cout_d  = 1'b0;
        ovf_d   = 1'b0;
        count_d = COUNT_ONE;
        if (state_q == ACCUM) begin
            cout_d  = cout_q | add_cout;
            ovf_d   = ovf_q | add_ovf;
            count_d = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_ONE;
        end
    end

    // Running packet state, advanced on every accepted beat.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            acc_q   <= add_sum;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    // Result registers are captured only on the last beat, so the outputs
    // keep the previous packet's result while a new packet accumulates.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_count_q <= '0;
        end else if (accept && IN_LAST) begin
            res_sum_q   <= add_sum;
            res_cout_q  <= cout_d;
            res_ovf_q   <= ovf_d;
            res_count_q <= count_d;
        end
    end

    assign OUT_SUM   = res_sum_q;
    assign OUT_COUT  = res_cout_q;
    assign OUT_OVF   = res_ovf_q;
    assign OUT_COUNT = res_count_q;

endmodule : ksa32_acc
